// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Two-port request arbiter and sequencer in front of the shared ALU. Each
// requester offers one operation over a valid/ready handshake. The arbiter
// grants the ALU round-robin, one operation at a time. For each granted
// operation it:
//   - drives the registered operands and opcode to the ALU,
//   - waits out the ALU output latency,
//   - captures the result bus selected by the opcode group,
//   - returns the result on a single backpressured response port.
//
// Parameters
//   WIDTH    operand/result width, must match the ALU data path
//   ALU_LAT  ALU output register latency in cycles, legal range 1..7
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   ReqN_Valid/ReqN_Ready    request handshake for requester N (0/1)
//   ReqN_A, ReqN_B, ReqN_FUN request operands and ALU opcode
//   Rsp_Valid/Rsp_Ready      response handshake
//   Rsp_ID                   requester that issued the operation
//   Rsp_Data                 captured result
//   Rsp_Carry                ALU carry, arithmetic group only
//   Rsp_Err                  selected unit flag was low at capture
//   ALU_A, ALU_B, ALU_FUN    registered operands/opcode towards the ALU
//   *_OUT, *_Flag, Carry_OUT ALU result buses and flags
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,

    // Requester 0
    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [WIDTH-1:0] Req0_A,
    input  logic [WIDTH-1:0] Req0_B,
    input  logic [3:0]       Req0_FUN,

    // Requester 1
    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [WIDTH-1:0] Req1_A,
    input  logic [WIDTH-1:0] Req1_B,
    input  logic [3:0]       Req1_FUN,

    // Response port
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic             Rsp_ID,
    output logic [WIDTH-1:0] Rsp_Data,
    output logic             Rsp_Carry,
    output logic             Rsp_Err,

    // ALU drive
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [3:0]       ALU_FUN,

    // ALU results
    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic [WIDTH-1:0] Logic_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] Shift_OUT,
    input  logic             Carry_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // Opcode 4'b1000 is the ALU NOP; the ALU idles on it between operations.
    localparam logic [3:0] FunNop = 4'b1000;
    // Exec counter value at which the ALU output is known to be registered.
    localparam logic [2:0] LatCnt = 3'(ALU_LAT);

    state_e           state_q;
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic             rr_ptr_q;
    logic             id_q;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_fun_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_carry_q;
    logic             rsp_err_q;

    // Arbitration and capture-selection helpers.
    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic [3:0]       grant_fun;
    logic [WIDTH-1:0] rsp_data_d;
    logic             rsp_carry_d;
    logic             rsp_err_d;

    // -----------------------------------------------------------------------
    // Grant: a lone valid wins outright; on contention rr_ptr picks.
    // -----------------------------------------------------------------------
    always_comb begin
        any_valid = Req0_Valid | Req1_Valid;
        if (Req0_Valid && Req1_Valid) begin
            grant_id = rr_ptr_q;
        end else begin
            grant_id = Req1_Valid;
        end

        if (grant_id) begin
            grant_a   = Req1_A;
            grant_b   = Req1_B;
            grant_fun = Req1_FUN;
        end else begin
            grant_a   = Req0_A;
            grant_b   = Req0_B;
            grant_fun = Req0_FUN;
        end
    end

    // Ready is combinational from the registered state; it is forced low
    // while reset is asserted so nothing can handshake during reset.
    assign accept     = (state_q == StIdle) & any_valid & ~RST;
    assign Req0_Ready = accept & ~grant_id;
    assign Req1_Ready = accept & grant_id;

    // -----------------------------------------------------------------------
    // Result selection by opcode group. Carry only has meaning for the
    // arithmetic unit, so it is masked for every other group.
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_data_d  = Arith_OUT;
        rsp_carry_d = 1'b0;
        rsp_err_d   = 1'b0;
        unique case (alu_fun_q[3:2])
            2'b00: begin
                rsp_data_d  = Arith_OUT;
                rsp_carry_d = Carry_OUT;
                rsp_err_d   = ~Arith_Flag;
            end
            2'b01: begin
                rsp_data_d = Logic_OUT;
                rsp_err_d  = ~Logic_Flag;
            end
            2'b10: begin
                rsp_data_d = CMP_OUT;
                rsp_err_d  = ~CMP_Flag;
            end
            2'b11: begin
                rsp_data_d = Shift_OUT;
                rsp_err_d  = ~Shift_Flag;
            end
            default: begin
                rsp_data_d  = Arith_OUT;
                rsp_carry_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    assign cnt_d = cnt_q + 3'd1;

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= FunNop;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        alu_a_q   <= grant_a;
                        alu_b_q   <= grant_b;
                        alu_fun_q <= grant_fun;
                        // The ID is held privately until capture so the
                        // response fields never move before Rsp_Valid.
                        id_q      <= grant_id;
                        cnt_q     <= '0;
                        rr_ptr_q  <= ~grant_id;
                        state_q   <= StExec;
                    end
                end

                StExec: begin
                    if (cnt_q == LatCnt) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= rsp_data_d;
                        rsp_carry_q <= rsp_carry_d;
                        rsp_err_q   <= rsp_err_d;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                StResp: begin
                    // Held indefinitely under backpressure; the ALU keeps its
                    // operands until the response is gone.
                    if (Rsp_Ready) begin
                        rsp_valid_q <= 1'b0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        alu_fun_q   <= FunNop;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;

    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_ID    = rsp_id_q;
    assign Rsp_Data  = rsp_data_q;
    assign Rsp_Carry = rsp_carry_q;
    assign Rsp_Err   = rsp_err_q;

endmodule
